mem_cmd_seq: RTL

//  Command sequencer directly upstream of the 64x8 memory array; sole driver of its port.

---
 rtl/mem_cmd_pkg.sv | 28 ++
 rtl/mem_cmd_fifo.sv | 60 ++++++
 rtl/mem_cmd_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the memory command sequencer.
//   ADDR_W / DATA_W : memory geometry, shared with the 64x8 memory array
//   state_t         : sequencer FSM states (verify states only with MEM_CMD_VERIFY_EN)
//   cmd_t           : queued command {we, addr, wdata}
package mem_cmd_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_RESP
`ifdef MEM_CMD_VERIFY_EN
    ,
    S_VFY_RD,
    S_VFY_WAIT
`endif
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous FIFO for queued commands.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push/i_din : write side (ignored when full)
//   i_pop/o_dout : read side, o_dout shows the head entry (pop ignored when empty)
//   o_full, o_empty, o_count : occupancy, o_count in 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module mem_cmd_fifo #(
  parameter int unsigned W     = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_seq.sv
// Command sequencer in front of the 64x8 memory array; sole driver of its port.
// Commands (valid/ready) are queued in mem_cmd_fifo, then issued one at a time
// as a single-cycle mem_wr_en or mem_rd_en strobe. Read data returns in command
// order on a valid/ready response channel; the next command is not popped
// while a response waits for rsp_ready.
// Ports:
//   wb_clk_i, wb_rst_i        : clock, asynchronous active-high reset
//   cmd_valid/ready/we/addr/wdata : command channel
//   rsp_valid/ready/data      : read response channel
//   mem_addr/wdata/wr_en/rd_en, mem_rdata : memory port (rdata valid one
//                               cycle after the edge that samples rd_en)
//   busy                      : FIFO non-empty or FSM not idle
//   verify_err                : sticky write-verify mismatch
// Build option MEM_CMD_VERIFY_EN: each write is followed by a read-back of the
// same address; a mismatch sets verify_err until reset. Undefined: verify_err=0.
module mem_cmd_seq
  import mem_cmd_pkg::*;
#(
  parameter int unsigned FIFO_D = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              verify_err
);

  localparam int unsigned CW = $clog2(FIFO_D + 1);

  cmd_t          w_cmd_in;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_pop;

  state_t            r_state,     w_state_nxt;
  logic              r_cur_we,    w_cur_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_wr_en,     w_wr_en_nxt;
  logic              r_rd_en,     w_rd_en_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data,  w_rsp_data_nxt;
`ifdef MEM_CMD_VERIFY_EN
  logic              r_verify_err, w_verify_err_nxt;
`endif

  assign w_cmd_in = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};

  mem_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (cmd_valid),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr_en = r_wr_en;
  assign mem_rd_en = r_rd_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`ifdef MEM_CMD_VERIFY_EN
  assign verify_err = r_verify_err;
`else
  assign verify_err = 1'b0;
`endif

  // Strobes default low so every strobe lasts exactly one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_we_nxt    = r_cur_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_pop           = 1'b0;
`ifdef MEM_CMD_VERIFY_EN
    w_verify_err_nxt = r_verify_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_count != '0) begin
          w_pop           = 1'b1;
          w_cur_we_nxt    = w_head.we;
          w_mem_addr_nxt  = w_head.addr;
          w_mem_wdata_nxt = w_head.wdata;
          w_wr_en_nxt     = w_head.we;
          w_rd_en_nxt     = !w_head.we;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cur_we) begin
`ifdef MEM_CMD_VERIFY_EN
          w_rd_en_nxt = 1'b1;
          w_state_nxt = S_VFY_RD;
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_rsp_data_nxt  = mem_rdata;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
`ifdef MEM_CMD_VERIFY_EN
      S_VFY_RD: begin
        w_state_nxt = S_VFY_WAIT;
      end
      // Read-back data arrives the cycle after the verify strobe is sampled.
      S_VFY_WAIT: begin
        if (mem_rdata != r_mem_wdata) w_verify_err_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cur_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef MEM_CMD_VERIFY_EN
      r_verify_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cur_we    <= w_cur_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
`ifdef MEM_CMD_VERIFY_EN
      r_verify_err <= w_verify_err_nxt;
`endif
    end
  end

endmodule
